// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
//
// Memory stage of a simple in-order pipeline. It owns a word-organised data
// memory (2^ADDR_W words of DATA_W bits), performs byte/half/word stores and
// sign- or zero-extended loads, resolves the branch decision and registers the
// result into the write-back (WB) stage register. Loads take MEM_LAT cycles.
// For MEM_LAT > 1 a small IDLE/WAIT FSM stalls the upstream stage until the
// data is ready.
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid          : stage input holds an instruction
//   reg_write, mem_to_reg, mem_read, mem_write, branch : control bits
//   zero_flag         : ALU zero result
//   mem_size          : 00 byte, 01 half, 10 word, 11 illegal
//   mem_unsigned      : zero-extend loads instead of sign-extending
//   flush             : squash the current and any in-flight operation
//   pc_target         : branch target address
//   alu_result        : byte address for memory ops, result otherwise
//   store_data        : store write data (right-aligned)
//   dest_reg          : destination register index
//   pc_src, pc_next   : branch taken flag and target (combinational)
//   stall             : upstream must hold its inputs this cycle
//   wb_*              : registered write-back stage outputs
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              branch,
    input  logic              zero_flag,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic              flush,
    input  logic [DATA_W-1:0] pc_target,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_AW-1:0] dest_reg,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_next,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic              wb_misalign,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [REG_AW-1:0] wb_dest_reg
);

    localparam int LANES = DATA_W / 8;
    localparam int CNT_W = 2;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Load context captured at acceptance; used while the FSM waits.
    logic [ADDR_W-1:0] ld_idx_q;
    logic [1:0]        ld_off_q;
    logic [1:0]        ld_size_q;
    logic              ld_uns_q;
    logic              ld_reg_write_q;
    logic              ld_mem_to_reg_q;
    logic [DATA_W-1:0] ld_alu_q;
    logic [REG_AW-1:0] ld_dest_q;

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_off;
    logic              in_wait;
    logic              misalign;
    logic              is_load;
    logic              accept;
    logic              store_en;
    logic              load_go;
    logic [LANES-1:0]  st_be;
    logic [DATA_W-1:0] st_wdata;
    logic [ADDR_W-1:0] rd_idx;
    logic [1:0]        rd_off;
    logic [1:0]        rd_size;
    logic              rd_uns;
    logic [DATA_W-1:0] rd_data;

    // Select byte/half from the low 32 bits of the word (little-endian) and
    // extend it; word accesses return the whole DATA_W word.
    function automatic logic [DATA_W-1:0] extend_load(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        off,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [31:0]       sh;
        logic [DATA_W-1:0] res;
        sh = word[31:0] >> {off, 3'b000};
        case (size)
            2'b00:   res = uns ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                           : {{(DATA_W-8){sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                           : {{(DATA_W-16){sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    assign pc_src  = in_valid & branch & zero_flag;
    assign pc_next = pc_target;

    assign word_idx = alu_result[ADDR_W+1:2];
    assign byte_off = alu_result[1:0];
    assign in_wait  = (state_q == S_WAIT);

    assign misalign = (mem_read | mem_write) &
                      ((mem_size == 2'b11) |
                       ((mem_size == 2'b01) & byte_off[0]) |
                       ((mem_size == 2'b10) & (byte_off != 2'b00)));

    // A simultaneous read+write is a store, so mem_read only counts alone.
    assign is_load  = mem_read & ~mem_write;
    // New instructions are only accepted in IDLE; during WAIT the upstream
    // is replaying the load being serviced.
    assign accept   = ~in_wait & in_valid & ~flush;
    assign store_en = rst_n & accept & mem_write & ~misalign;
    assign load_go  = accept & is_load & ~misalign;

    assign stall = rst_n & (((MEM_LAT > 1) & load_go) |
                            (in_wait & (cnt_q != '0)));

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        st_be    = '0;
        st_wdata = store_data;
        case (mem_size)
            2'b00: begin
                st_be[byte_off] = 1'b1;
                st_wdata        = {LANES{store_data[7:0]}};
            end
            2'b01: begin
                st_be[{byte_off[1], 1'b0} +: 2] = 2'b11;
                st_wdata = {(DATA_W/16){store_data[15:0]}};
            end
            default: st_be = '1;
        endcase
    end

    assign rd_idx  = in_wait ? ld_idx_q  : word_idx;
    assign rd_off  = in_wait ? ld_off_q  : byte_off;
    assign rd_size = in_wait ? ld_size_q : mem_size;
    assign rd_uns  = in_wait ? ld_uns_q  : mem_unsigned;
    // Asynchronous read: a store written at the previous edge is visible here.
    assign rd_data = extend_load(mem[rd_idx], rd_off, rd_size, rd_uns);

    // NOTE: the memory array has no reset; its contents survive rst_n and
    // only byte lanes enabled by the store are updated.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (st_be[b]) begin
                    mem[word_idx][b*8 +: 8] <= st_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept & is_load) begin
            ld_idx_q        <= word_idx;
            ld_off_q        <= byte_off;
            ld_size_q       <= mem_size;
            ld_uns_q        <= mem_unsigned;
            ld_reg_write_q  <= reg_write;
            ld_mem_to_reg_q <= mem_to_reg;
            ld_alu_q        <= alu_result;
            ld_dest_q       <= dest_reg;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values. The leading defaults load a bubble; later
    // assignments in the same block override them.
    always_ff @(posedge clk) begin
        wb_valid      <= 1'b0;
        wb_reg_write  <= 1'b0;
        wb_mem_to_reg <= 1'b0;
        wb_misalign   <= 1'b0;
        wb_alu_result <= '0;
        wb_mem_data   <= '0;
        wb_dest_reg   <= '0;

        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (in_wait) begin
            if (cnt_q == '0) begin
                state_q       <= S_IDLE;
                wb_valid      <= 1'b1;
                wb_reg_write  <= ld_reg_write_q;
                wb_mem_to_reg <= ld_mem_to_reg_q;
                wb_alu_result <= ld_alu_q;
                wb_mem_data   <= rd_data;
                wb_dest_reg   <= ld_dest_q;
            end else begin
                cnt_q <= cnt_q - 2'd1;
            end
        end else if (in_valid) begin
            if ((MEM_LAT > 1) && load_go) begin
                state_q <= S_WAIT;
                cnt_q   <= CNT_W'(MEM_LAT - 2);
            end else begin
                wb_valid      <= 1'b1;
                wb_reg_write  <= reg_write & ~misalign;
                wb_mem_to_reg <= mem_to_reg;
                wb_misalign   <= misalign;
                wb_alu_result <= alu_result;
                wb_mem_data   <= load_go ? rd_data : '0;
                wb_dest_reg   <= dest_reg;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
//
// Three instances of mem_stage (MEM_LAT = 1, 3, 4) share one stimulus bus;
// each has its own in_valid so only the addressed instance sees instructions.
// A byte-addressed reference model predicts the WB register and stall for
// every instance; a compare process checks them on each falling edge.
// Directed sequences add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int LAT [3] = '{1, 3, 4};

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        m2r;
        logic        mis;
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [4:0]  dest;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid_v;
    logic        reg_write, mem_to_reg, mem_read, mem_write, branch, zero_flag;
    logic [1:0]  mem_size;
    logic        mem_unsigned, flush;
    logic [31:0] pc_target, alu_result, store_data;
    logic [4:0]  dest_reg;

    logic [2:0]       pc_src_w, stall_w, wb_valid_w, wb_reg_write_w;
    logic [2:0]       wb_mem_to_reg_w, wb_misalign_w;
    logic [2:0][31:0] pc_next_w, wb_alu_w, wb_mdata_w;
    logic [2:0][4:0]  wb_dest_w;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] mem_b [3][1024];
    wb_t        exp_wb [3];
    wb_t        pend [3];
    int         due [3];
    logic       rst_seen = 1'b0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(32), .ADDR_W(8), .REG_AW(5), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .zero_flag(zero_flag),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .flush(flush),
        .pc_target(pc_target), .alu_result(alu_result), .store_data(store_data),
        .dest_reg(dest_reg), .pc_src(pc_src_w[0]), .pc_next(pc_next_w[0]),
        .stall(stall_w[0]), .wb_valid(wb_valid_w[0]),
        .wb_reg_write(wb_reg_write_w[0]), .wb_mem_to_reg(wb_mem_to_reg_w[0]),
        .wb_misalign(wb_misalign_w[0]), .wb_alu_result(wb_alu_w[0]),
        .wb_mem_data(wb_mdata_w[0]), .wb_dest_reg(wb_dest_w[0])
    );

    mem_stage #(.DATA_W(32), .ADDR_W(8), .REG_AW(5), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .zero_flag(zero_flag),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .flush(flush),
        .pc_target(pc_target), .alu_result(alu_result), .store_data(store_data),
        .dest_reg(dest_reg), .pc_src(pc_src_w[1]), .pc_next(pc_next_w[1]),
        .stall(stall_w[1]), .wb_valid(wb_valid_w[1]),
        .wb_reg_write(wb_reg_write_w[1]), .wb_mem_to_reg(wb_mem_to_reg_w[1]),
        .wb_misalign(wb_misalign_w[1]), .wb_alu_result(wb_alu_w[1]),
        .wb_mem_data(wb_mdata_w[1]), .wb_dest_reg(wb_dest_w[1])
    );

    mem_stage #(.DATA_W(32), .ADDR_W(8), .REG_AW(5), .MEM_LAT(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .zero_flag(zero_flag),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .flush(flush),
        .pc_target(pc_target), .alu_result(alu_result), .store_data(store_data),
        .dest_reg(dest_reg), .pc_src(pc_src_w[2]), .pc_next(pc_next_w[2]),
        .stall(stall_w[2]), .wb_valid(wb_valid_w[2]),
        .wb_reg_write(wb_reg_write_w[2]), .wb_mem_to_reg(wb_mem_to_reg_w[2]),
        .wb_misalign(wb_misalign_w[2]), .wb_alu_result(wb_alu_w[2]),
        .wb_mem_data(wb_mdata_w[2]), .wb_dest_reg(wb_dest_w[2])
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic misal_now();
        logic [1:0] a;
        a = alu_result[1:0];
        if (!(mem_read || mem_write)) return 1'b0;
        if (mem_size == 2'b11) return 1'b1;
        if (mem_size == 2'b01) return a[0];
        if (mem_size == 2'b10) return a != 2'b00;
        return 1'b0;
    endfunction

    // Execute the current input instruction on model k: performs the store
    // into the byte array and builds the WB record.
    task automatic exec(input int k, output wb_t r);
        logic       mis;
        logic [9:0] a;
        logic [7:0] v8;
        logic [15:0] v16;
        a   = alu_result[9:0];
        mis = misal_now();
        r       = '0;
        r.valid = 1'b1;
        r.rw    = reg_write && !mis;
        r.m2r   = mem_to_reg;
        r.mis   = mis;
        r.alu   = alu_result;
        r.dest  = dest_reg;
        if (mem_write && !mis) begin
            mem_b[k][a] = store_data[7:0];
            if (mem_size != 2'b00) mem_b[k][a+10'd1] = store_data[15:8];
            if (mem_size == 2'b10) begin
                mem_b[k][a+10'd2] = store_data[23:16];
                mem_b[k][a+10'd3] = store_data[31:24];
            end
        end else if (mem_read && !mis) begin
            case (mem_size)
                2'b00: begin
                    v8 = mem_b[k][a];
                    r.mdata = (mem_unsigned || !v8[7]) ? {24'h0, v8} : {24'hFFFFFF, v8};
                end
                2'b01: begin
                    v16 = {mem_b[k][a+10'd1], mem_b[k][a]};
                    r.mdata = (mem_unsigned || !v16[15]) ? {16'h0, v16} : {16'hFFFF, v16};
                end
                default: r.mdata = {mem_b[k][a+10'd3], mem_b[k][a+10'd2],
                                    mem_b[k][a+10'd1], mem_b[k][a]};
            endcase
        end
    endtask

    task automatic model_step();
        wb_t r;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n || flush) begin
                exp_wb[k] = '0;
                due[k]    = 0;
            end else if (due[k] != 0) begin
                due[k]--;
                exp_wb[k] = (due[k] == 0) ? pend[k] : '0;
            end else if (!in_valid_v[k]) begin
                exp_wb[k] = '0;
            end else begin
                exec(k, r);
                if (mem_read && !mem_write && !r.mis && LAT[k] > 1) begin
                    pend[k]   = r;
                    due[k]    = LAT[k] - 1;
                    exp_wb[k] = '0;
                end else begin
                    exp_wb[k] = r;
                end
            end
        end
        if (!rst_n) rst_seen = 1'b1;
    endtask

    function automatic logic exp_stall(int k);
        if (!rst_n) return 1'b0;
        if (due[k] != 0) return due[k] > 1;
        return in_valid_v[k] && !flush && mem_read && !mem_write &&
               !misal_now() && LAT[k] > 1;
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            exp_wb[k] = '0;
            pend[k]   = '0;
            due[k]    = 0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare process: every falling edge once reset has been applied.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("u%0d.stall", k), stall_w[k], exp_stall(k));
                    check($sformatf("u%0d.pc_src", k), pc_src_w[k],
                          in_valid_v[k] & branch & zero_flag);
                    check($sformatf("u%0d.pc_next", k), pc_next_w[k], pc_target);
                    check($sformatf("u%0d.wb_valid", k), wb_valid_w[k], exp_wb[k].valid);
                    if (exp_wb[k].valid) begin
                        check($sformatf("u%0d.wb_reg_write", k), wb_reg_write_w[k], exp_wb[k].rw);
                        check($sformatf("u%0d.wb_mem_to_reg", k), wb_mem_to_reg_w[k], exp_wb[k].m2r);
                        check($sformatf("u%0d.wb_misalign", k), wb_misalign_w[k], exp_wb[k].mis);
                        check($sformatf("u%0d.wb_alu_result", k), wb_alu_w[k], exp_wb[k].alu);
                        check($sformatf("u%0d.wb_mem_data", k), wb_mdata_w[k], exp_wb[k].mdata);
                        check($sformatf("u%0d.wb_dest_reg", k), wb_dest_w[k], exp_wb[k].dest);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        in_valid_v   = '0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        branch       = 1'b0;
        zero_flag    = 1'b0;
        mem_size     = 2'b10;
        mem_unsigned = 1'b0;
        flush        = 1'b0;
        pc_target    = '0;
        alu_result   = '0;
        store_data   = '0;
        dest_reg     = '0;
    endtask

    task automatic drive(input int k, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic rw);
        set_idle();
        in_valid_v[k] = 1'b1;
        mem_read      = rd;
        mem_write     = wr;
        mem_size      = sz;
        mem_unsigned  = uns;
        alu_result    = addr;
        store_data    = sd;
        reg_write     = rw;
        mem_to_reg    = rd & ~wr;
        dest_reg      = addr[6:2];
        pc_target     = addr + 32'h100;
    endtask

    // Called just after a rising edge; holds the instruction for 'hold'
    // cycles and returns just after the edge that writes it back.
    task automatic issue(input int k, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic rw, input int hold);
        drive(k, rd, wr, sz, uns, addr, sd, rw);
        repeat (hold) @(posedge clk);
        #1;
        set_idle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        set_idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        // Load and taken branch presented while reset is held.
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1);
        branch    = 1'b1;
        zero_flag = 1'b1;
        @(negedge clk);
        check("rst_stall", stall_w[1], 1'b0);
        check("rst_pc_src", pc_src_w[1], 1'b1);
        check("rst_wb_valid", wb_valid_w[1], 1'b0);
        check("rst_wb_alu", wb_alu_w[1], 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_idle();

        // ---- MEM_LAT = 1 ----
        issue(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1);
        check("sw_wb_valid", wb_valid_w[0], 1'b1);
        check("sw_mem_data_zero", wb_mdata_w[0], 32'h0);
        issue(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1);
        check("lw_fwd_data", wb_mdata_w[0], 32'hDEADBEEF);
        check("lw_fwd_valid", wb_valid_w[0], 1'b1);

        issue(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80F07F01, 1'b0, 1);
        issue(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b1, 1);
        check("lb_0x23", wb_mdata_w[0], 32'hFFFFFF80);
        issue(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b1, 1);
        check("lbu_0x23", wb_mdata_w[0], 32'h00000080);
        issue(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b1, 1);
        check("lh_0x20", wb_mdata_w[0], 32'h00007F01);
        issue(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 1'b0, 1);
        issue(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1);
        check("lw_after_sb", wb_mdata_w[0], 32'h80F0AA01);

        issue(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h12345678, 1'b1, 1);
        check("sw_mis_flag", wb_misalign_w[0], 1'b1);
        check("sw_mis_rw", wb_reg_write_w[0], 1'b0);
        check("sw_mis_valid", wb_valid_w[0], 1'b1);
        issue(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1);
        check("mem_unchanged", wb_mdata_w[0], 32'h80F0AA01);
        issue(0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b1, 1);
        check("size11_mis", wb_misalign_w[0], 1'b1);

        drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        branch    = 1'b1;
        zero_flag = 1'b1;
        pc_target = 32'h40;
        #1;
        check("br_taken", pc_src_w[0], 1'b1);
        check("br_pc_next", pc_next_w[0], 32'h40);
        zero_flag = 1'b0;
        #1;
        check("br_not_taken", pc_src_w[0], 1'b0);
        @(posedge clk); #1;
        set_idle();

        // ---- MEM_LAT = 3 ----
        issue(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 1'b0, 1);
        drive(1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b1);
        @(negedge clk);
        check("lh_mis_no_stall", stall_w[1], 1'b0);
        @(posedge clk); #1;
        set_idle();
        check("lh_mis_flag", wb_misalign_w[1], 1'b1);
        check("lh_mis_rw", wb_reg_write_w[1], 1'b0);
        check("lh_mis_valid", wb_valid_w[1], 1'b1);

        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1);
        @(negedge clk);
        check("lat3_stall_c0", stall_w[1], 1'b1);
        @(negedge clk);
        check("lat3_stall_c1", stall_w[1], 1'b1);
        check("lat3_bubble_1", wb_valid_w[1], 1'b0);
        @(negedge clk);
        check("lat3_stall_c2", stall_w[1], 1'b0);
        check("lat3_bubble_2", wb_valid_w[1], 1'b0);
        @(posedge clk); #1;
        set_idle();
        check("lat3_valid", wb_valid_w[1], 1'b1);
        check("lat3_data", wb_mdata_w[1], 32'hCAFEF00D);

        // read+write together is a store and never stalls
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h34, 32'h13579BDF, 1'b0);
        @(negedge clk);
        check("rdwr_no_stall", stall_w[1], 1'b0);
        @(posedge clk); #1;
        set_idle();
        issue(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h34, 32'h0, 1'b1, 3);
        check("rdwr_stored", wb_mdata_w[1], 32'h13579BDF);

        // store squashed by flush
        drive(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h34, 32'hFFFFFFFF, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        set_idle();
        check("flush_st_bubble", wb_valid_w[1], 1'b0);
        issue(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h34, 32'h0, 1'b1, 3);
        check("flush_st_no_write", wb_mdata_w[1], 32'h13579BDF);

        // ---- MEM_LAT = 4 ----
        issue(2, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0BADCAFE, 1'b0, 1);
        issue(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 4);
        check("lat4_data", wb_mdata_w[2], 32'h0BADCAFE);

        // flush in the second stall cycle
        drive(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check("flush_stall_off", stall_w[2], 1'b0);
        check("flush_bubble", wb_valid_w[2], 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("flush_no_late_wb", wb_valid_w[2], 1'b0);
        end
        @(posedge clk); #1;

        // reset in the second stall cycle
        drive(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_idle();
        @(negedge clk);
        check("rst_stall_off", stall_w[2], 1'b0);
        check("rst_bubble", wb_valid_w[2], 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("rst_no_late_wb", wb_valid_w[2], 1'b0);
        end
        @(posedge clk); #1;

        // memory survives reset
        issue(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 4);
        check("mem_after_rst", wb_mdata_w[2], 32'h0BADCAFE);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
